// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encoding, frame geometry and the
// baud-divider calculation used by both link directions.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned uart_freq);
    return (clk_freq + uart_freq / 2) / uart_freq;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy; DEPTH must be a power of two.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [DATA_BITS-1:0]     wdata_i,
  input  logic                     pop_i,
  output logic [DATA_BITS-1:0]     rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned Aw = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [Aw-1:0]        wptr_q, rptr_q;
  logic [Aw:0]          count_q, count_d;
  logic                 do_push, do_pop;

  // Power-of-two depth: count reaches DEPTH exactly when its MSB is set.
  assign full_o  = count_q[Aw];
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (Aw + 1)'(1);
      2'b01:   count_d = count_q - (Aw + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + Aw'(1);
      if (do_pop)  rptr_q <= rptr_q + Aw'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: FIFO-fed, LSB first, frames start only while
// the synchronised peer cts is low.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 12000000,
  parameter int unsigned UART_FREQ  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          wr_i,
  input  logic [7:0]                    di_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          ovf_o,
  input  logic                          cts_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          tx_done_o
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, UART_FREQ);
  localparam int unsigned CntW = $clog2(Div);
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);
  localparam logic [2:0]      BitLast = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CntW-1:0]      baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q;
  logic                 cts_meta_q, cts_s_q;
  logic                 pop;
  logic [7:0]           fifo_rdata;
  logic                 baud_last;

  uart_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (wr_i),
    .wdata_i (di_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (full_o),
    .empty_o (empty_o),
    .level_o (level_o)
  );

  assign baud_last = (baud_q == CntLast);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty_o && !cts_s_q) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        baud_d = baud_q + CntW'(1);
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        baud_d = baud_q + CntW'(1);
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BitLast) state_d = StStop;
          else                  bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        baud_d = baud_q + CntW'(1);
        if (baud_last) begin
          baud_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // tx is registered from the next state so the line never glitches.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cts_meta_q <= 1'b1;
      cts_s_q    <= 1'b1;
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      cts_meta_q <= cts_i;
      cts_s_q    <= cts_meta_q;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ovf_q      <= wr_i & full_o;
    end
  end

  assign tx_o      = tx_q;
  assign ovf_o     = ovf_q;
  assign busy_o    = (state_q != StIdle);
  assign tx_done_o = (state_q == StStop) && baud_last;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus a random phase,
// every cycle compared against a frame-level reference model.
module tb_uart_tx_fifo;

  localparam int Div       = 8;
  localparam int Depth     = 4;
  localparam int FrameClks = 10 * Div;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] di = 8'h00;
  logic       cts = 1'b1;
  logic       full, empty, ovf, tx, busy, tx_done;
  logic [2:0] level;

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;

  uart_tx_fifo #(
    .CLK_FREQ   (8),
    .UART_FREQ  (1),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_i      (wr),
    .di_i      (di),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (level),
    .ovf_o     (ovf),
    .cts_i     (cts),
    .tx_o      (tx),
    .busy_o    (busy),
    .tx_done_o (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending bytes and a frame timer; the line value
  // is derived from the elapsed clock count within the current frame.
  logic [7:0] mq[$];
  logic       m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_cts1 = 1'b1, m_cts2 = 1'b1;
  logic       m_ovf = 1'b0;

  always @(posedge clk or posedge reset) begin
    int   pre_size;
    logic start;
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_t = 0;
      m_cts1 = 1'b1;
      m_cts2 = 1'b1;
      m_ovf = 1'b0;
    end else begin
      pre_size = mq.size();
      start = !m_active && pre_size != 0 && !m_cts2;
      if (m_active) begin
        if (m_t == FrameClks - 1) m_active = 1'b0;
        else m_t++;
      end
      if (start) begin
        m_byte = mq.pop_front();
        m_active = 1'b1;
        m_t = 0;
      end
      m_ovf = wr && pre_size == Depth;
      if (wr && pre_size < Depth) mq.push_back(di);
      m_cts2 = m_cts1;
      m_cts1 = cts;
    end
  end

  function automatic logic exp_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_t / Div;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[b-1];
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    check("tx", tx, exp_tx());
    check("busy", busy, m_active);
    check("tx_done", tx_done, m_active && m_t == FrameClks - 1);
    check("level", level, mq.size());
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == Depth);
    check("ovf", ovf, m_ovf);
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!(empty === 1'b1 && busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {empty, busy}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, peak;
    logic [7:0] r1, r2, r3, r4;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // 1: single frame 0xA5, latency and frame length
    cts = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    wr = 1'b1; di = 8'hA5;
    @(negedge clk); wr = 1'b0;
    for (int i = 1; i <= 81; i++) begin
      @(negedge clk);
      if (i == 1)  check("t1_start_low", tx, 1'b0);
      if (i == 9)  check("t1_bit0", tx, 1'b1);
      if (i == 17) check("t1_bit1", tx, 1'b0);
      if (i == 80) check("t1_done_at_80", tx_done, 1'b1);
      if (i == 81) check("t1_busy_end", busy, 1'b0);
    end
    check("t1_done_count", done_cnt - d0, 1);

    // 2: three back-to-back bytes
    d0 = done_cnt;
    peak = 0;
    @(negedge clk); wr = 1'b1; di = 8'h00;
    @(negedge clk); di = 8'hFF;
    @(negedge clk); di = 8'h55;
    @(negedge clk); wr = 1'b0;
    for (int i = 0; i < 300 && !(empty === 1'b1 && busy === 1'b0); i++) begin
      if (int'(level) > peak) peak = int'(level);
      @(negedge clk);
    end
    check("t2_peak_level", peak, 2);
    check("t2_done_count", done_cnt - d0, 3);
    check("t2_empty", empty, 1'b1);

    // 3: fill while blocked, overflow, then release
    cts = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    wr = 1'b1; di = 8'h01;
    @(negedge clk); di = 8'h02;
    @(negedge clk); di = 8'h03;
    @(negedge clk); di = 8'h04;
    @(negedge clk); di = 8'h05;
    check("t3_full_after_4", full, 1'b1);
    @(negedge clk); wr = 1'b0;
    check("t3_ovf_pulse", ovf, 1'b1);
    @(negedge clk);
    check("t3_ovf_clear", ovf, 1'b0);
    repeat (4) @(negedge clk);
    check("t3_tx_idle", tx, 1'b1);
    cts = 1'b0;
    @(negedge clk); check("t3_wait1", tx, 1'b1);
    @(negedge clk); check("t3_wait2", tx, 1'b1);
    @(negedge clk); check("t3_start", tx, 1'b0);
    drain("t3_drain", 400);
    check("t3_done_count", done_cnt - d0, 4);

    // 4: cts rises mid-frame with a byte queued
    r1 = 8'($urandom);
    d0 = done_cnt;
    wr = 1'b1; di = 8'h3C;
    @(negedge clk); di = r1;
    @(negedge clk); wr = 1'b0;
    repeat (18) @(negedge clk);
    cts = 1'b1;
    repeat (65) @(negedge clk);
    check("t4_done_count", done_cnt - d0, 1);
    check("t4_level_held", level, 1);
    check("t4_busy", busy, 1'b0);
    cts = 1'b0;
    drain("t4_drain", 200);

    // 5: asynchronous reset during data bit 3
    r1 = 8'($urandom); r2 = 8'($urandom);
    wr = 1'b1; di = 8'h81;
    @(negedge clk); di = r1;
    @(negedge clk); di = r2;
    @(negedge clk); wr = 1'b0;
    check("t5_level_before", level, 2);
    repeat (33) @(negedge clk);
    d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("t5_rst_tx", tx, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_level", level, 0);
    check("t5_rst_empty", empty, 1'b1);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t5_quiet_tx", tx, 1'b1);
    end
    check("t5_no_done", done_cnt - d0, 0);

    // 6: push on the same edge as the pop
    r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom); r4 = 8'($urandom);
    cts = 1'b1;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    wr = 1'b1; di = r1;
    @(negedge clk); di = r2;
    @(negedge clk); di = r3;
    @(negedge clk); wr = 1'b0;
    cts = 1'b0;
    @(negedge clk);
    @(negedge clk); wr = 1'b1; di = r4;
    @(negedge clk); wr = 1'b0;
    check("t6_level_same", level, 3);
    check("t6_no_ovf", ovf, 1'b0);
    check("t6_busy", busy, 1'b1);
    drain("t6_drain", 400);
    check("t6_done_count", done_cnt - d0, 4);

    // Random traffic with occasional cts toggles
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr = ($urandom_range(0, 5) == 0);
      di = 8'($urandom);
      if ($urandom_range(0, 40) == 0) cts = ~cts;
    end
    @(negedge clk);
    wr = 1'b0;
    cts = 1'b0;
    drain("rand_drain", 600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered, flow-controlled UART transmitter (8N1) forming the sending end of a UART link.
- Its cts input connects to the cts output of the receiving peer peripheral (low = peer accepts data).
- Bytes written by the local master are queued in a small FIFO and serialised LSB-first on tx.
- A new frame starts only while the synchronised cts is low.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
UART_FREQ, 115200, baud rate in Hz; bit period DIV = (CLK_FREQ + UART_FREQ/2) / UART_FREQ, rounded to nearest (104 at defaults); DIV >= 2 required
FIFO_DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
wr  input  1  write strobe; pushes di when not full
di  input  8  byte to transmit
full  output  1  FIFO holds FIFO_DEPTH bytes
empty  output  1  FIFO holds 0 bytes
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
ovf  output  1  one-cycle pulse: wr while full, byte dropped
cts  input  1  peer flow control, asynchronous; low = peer accepts
tx  output  1  serial line, idle high
busy  output  1  high while a frame is in START/DATA/STOP
tx_done  output  1  one-cycle pulse at the end of each stop bit

Behaviour:
- Reset (async, any time, including mid-frame):
  - tx=1, state IDLE, FIFO empty (level=0, empty=1, full=0).
  - ovf=0, tx_done=0, busy=0; baud and bit counters 0.
  - Both cts synchroniser flops = 1 (not accepting). A partial frame is abandoned; tx returns high immediately.
- cts is passed through a 2-flop synchroniser giving cts_s. A level change is visible in cts_s after 2 clk edges.
- FIFO write:
  - Edge with wr=1 and full=0 stores di; level increments after that edge.
  - Edge with wr=1 and full=1 drops di and pulses ovf for one cycle.
  - full, empty and level are registered values.
- FIFO pop: occurs only on the IDLE->START transition. A simultaneous push and pop leaves level unchanged; both succeed.
- FSM states:
  - IDLE: tx=1. When empty=0 and cts_s=0 at an edge: pop the head byte into the shift register, reset the baud counter, go to START.
  - START: tx=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for DIV clocks per bit, shifting right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for DIV clocks. On the final clock, pulse tx_done and go to IDLE.
- Latency: a wr at edge N into an empty FIFO, with cts_s already 0, makes tx low after edge N+1.
- Frame timing:
  - A frame is exactly 10*DIV clocks.
  - Back-to-back frames have exactly 1 clk of IDLE between the stop bit and the next start bit.
- Flow control:
  - cts_s is sampled only in IDLE.
  - cts rising mid-frame does not abort the frame; it completes and no further frame starts until cts_s=0.
- busy=1 exactly in START/DATA/STOP.
- Baud counter counts 0..DIV-1 and wraps; it is the sole bit timer.
- Bit index is 3 bits; FIFO pointers are log2(FIFO_DEPTH) bits with natural wrap-around.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - DATA_BITS=8 and FRAME_BITS=10.
  - DIV computation function, shared with the receiver side.
- One sub-module, uart_fifo: synchronous FIFO with parameter DEPTH, width 8, push/pop/full/empty/level, async active-high reset. The FSM, synchroniser and baud counter live in uart_tx_fifo.

Test Plan (CLK_FREQ=8, UART_FREQ=1 -> DIV=8, FIFO_DEPTH=4):
1. cts=0 held; write 0xA5 at edge N.
   - Required: tx low after edge N+1 for 8 clks.
   - Then data bits 1,0,1,0,0,1,0,1 at 8 clks each, then stop high for 8 clks.
   - tx_done pulses once at clk N+80; busy high for 80 clks.
2. cts=0; write 0x00, 0xFF, 0x55 on consecutive edges.
   - Required: level peaks at 2 (first pop is immediate).
   - Three frames, each separated by exactly 1 idle clk; 3 tx_done pulses; empty=1 at end.
3. cts=1; write 5 bytes 0x01..0x05.
   - Required: full=1 after the 4th write; the 5th write pulses ovf; tx stays high.
   - Then drive cts=0: tx falls 3 edges later; bytes 0x01..0x04 are sent in order, 0x05 is never sent.
4. cts=0; start frame 0x3C; raise cts at clk 20 of the frame with a second byte queued.
   - Required: the 0x3C frame completes intact; the second byte stays queued (level=1) until cts returns low.
5. Assert reset during DATA bit 3 of frame 0x81 with 2 bytes queued.
   - Required: tx=1, busy=0, level=0, empty=1 immediately (asynchronous); no tx_done.
   - After release with cts=0, tx stays high until a new write.
6. cts=0; FIFO holds 3 bytes; drive wr on the same edge as the IDLE->START pop.
   - Required: level unchanged at 3; no ovf; all 4 bytes are sent in write order.
